// File: rtl/klp32_pkg.sv
// Shared KLP32 pipeline-control types and constants.
// Sequencer state encoding plus opcode/NOP values used by the surrounding pipeline.
package klp32_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOAD_USE = 2'd1,
        MEM_WAIT = 2'd2,
        REDIRECT = 2'd3
    } ctrl_state_t;

    localparam logic [6:0]  OPC_LOAD = 7'b0000011;
    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous reset.
// It stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// KLP32 pipeline sequencer: per-stage enables/flushes from memory waits, redirects and load-use hazards.
// Outputs are combinational from the registered state and the current hazard inputs.
module pipeline_ctrl
    import klp32_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int REDIRECT_FLUSH = 2,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_reg_wr_en,
    input  logic             i_ex_is_load,
    input  logic             i_mem_redirect,
    input  logic             i_mem_req,
    input  logic             i_mem_rdy,
    output logic             o_pc_en,
    output logic             o_fd_en,
    output logic             o_de_en,
    output logic             o_em_en,
    output logic             o_mw_en,
    output logic             o_fd_flush,
    output logic             o_de_flush,
    output logic             o_em_flush,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_redirects,
    output logic             o_mem_timeout
);

    localparam int                WAIT_W     = 12;
    localparam logic [2:0]        RF_RELOAD  = 3'(REDIRECT_FLUSH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    ctrl_state_t       state_reg, state_next;
    ctrl_state_t       saved_state_reg, saved_state_next;
    ctrl_state_t       eff_state;
    logic [2:0]        rem_reg, rem_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_inc;
    logic              timeout_reg;
    logic              mw, lu;
    logic              pc_en, fd_en, de_en, em_en, mw_en;
    logic              fd_flush, de_flush, em_flush;
    logic              redirect_inc;

    assign mw = i_mem_req & ~i_mem_rdy;
    assign lu = i_ex_is_load & i_ex_reg_wr_en & (i_ex_rd != 5'd0) &
                ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                 (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

    // rem_reg is untouched during a freeze, so only the pre-wait state needs saving.
    assign eff_state    = (state_reg == MEM_WAIT) ? saved_state_reg : state_reg;
    assign wait_cnt_inc = (wait_cnt_reg == '1) ? wait_cnt_reg : wait_cnt_reg + WAIT_W'(1);

    always_comb begin
        state_next       = state_reg;
        saved_state_next = saved_state_reg;
        rem_next         = rem_reg;
        {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
        {fd_flush, de_flush, em_flush}      = 3'b000;
        redirect_inc     = 1'b0;
        if (mw) begin
            {pc_en, fd_en, de_en, em_en, mw_en} = 5'b00000;
            state_next = MEM_WAIT;
            if (state_reg != MEM_WAIT) begin
                saved_state_next = state_reg;
            end
        end else if (i_mem_redirect) begin
            // Decode holds a wrong-path instruction, so any load-use hit is moot.
            {fd_flush, de_flush, em_flush} = 3'b111;
            redirect_inc = 1'b1;
            if (REDIRECT_FLUSH > 1) begin
                state_next = REDIRECT;
                rem_next   = RF_RELOAD;
            end else begin
                state_next = RUN;
                rem_next   = 3'd0;
            end
        end else begin
            case (eff_state)
                REDIRECT: begin
                    fd_flush   = 1'b1;
                    de_flush   = 1'b1;
                    rem_next   = rem_reg - 3'd1;
                    state_next = (rem_reg == 3'd1) ? RUN : REDIRECT;
                end
                LOAD_USE: begin
                    state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                    if (lu) begin
                        pc_en      = 1'b0;
                        fd_en      = 1'b0;
                        de_flush   = 1'b1;
                        state_next = LOAD_USE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= RUN;
            saved_state_reg <= RUN;
            rem_reg         <= 3'd0;
            wait_cnt_reg    <= '0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            saved_state_reg <= saved_state_next;
            rem_reg         <= rem_next;
            if (mw) begin
                wait_cnt_reg <= wait_cnt_inc;
                if (wait_cnt_inc >= WAIT_LIMIT) begin
                    timeout_reg <= 1'b1;
                end
            end else begin
                wait_cnt_reg <= '0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_en),
        .count (o_stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_inc),
        .count (o_redirects)
    );

    // While reset is held the pipeline runs free, whatever the hazard inputs say.
    assign o_pc_en       = reset | pc_en;
    assign o_fd_en       = reset | fd_en;
    assign o_de_en       = reset | de_en;
    assign o_em_en       = reset | em_en;
    assign o_mw_en       = reset | mw_en;
    assign o_fd_flush    = ~reset & fd_flush;
    assign o_de_flush    = ~reset & de_flush;
    assign o_em_flush    = ~reset & em_flush;
    assign o_state       = state_reg;
    assign o_mem_timeout = timeout_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared against an event-level model of the flush/stall/freeze rules.
module tb_pipeline_ctrl;

    localparam int CNT_W   = 8;
    localparam int RF      = 2;
    localparam int TMO     = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       i_id_rs1, i_id_rs2, i_ex_rd;
    logic             i_id_use_rs1, i_id_use_rs2, i_ex_reg_wr_en, i_ex_is_load;
    logic             i_mem_redirect, i_mem_req, i_mem_rdy;
    logic             o_pc_en, o_fd_en, o_de_en, o_em_en, o_mw_en;
    logic             o_fd_flush, o_de_flush, o_em_flush;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_stall_cycles, o_redirects;
    logic             o_mem_timeout;
    logic [9:0]       dut_vec;

    int n_pass  = 0;
    int n_total = 0;

    // Model: remaining Fetch/Decode flush cycles, load-use mask, freeze flag, wait length.
    int m_flush_left, m_wait, m_stalls, m_redirs;
    bit m_lu_mask, m_frozen, m_timeout;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CNT_W), .REDIRECT_FLUSH(RF), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
        .i_ex_rd(i_ex_rd), .i_ex_reg_wr_en(i_ex_reg_wr_en), .i_ex_is_load(i_ex_is_load),
        .i_mem_redirect(i_mem_redirect), .i_mem_req(i_mem_req), .i_mem_rdy(i_mem_rdy),
        .o_pc_en(o_pc_en), .o_fd_en(o_fd_en), .o_de_en(o_de_en), .o_em_en(o_em_en),
        .o_mw_en(o_mw_en), .o_fd_flush(o_fd_flush), .o_de_flush(o_de_flush),
        .o_em_flush(o_em_flush), .o_state(o_state), .o_stall_cycles(o_stall_cycles),
        .o_redirects(o_redirects), .o_mem_timeout(o_mem_timeout)
    );

    assign dut_vec = {o_pc_en, o_fd_en, o_de_en, o_em_en, o_mw_en,
                      o_fd_flush, o_de_flush, o_em_flush, o_state};

    function automatic void model_reset();
        m_flush_left = 0; m_wait = 0; m_stalls = 0; m_redirs = 0;
        m_lu_mask = 0; m_frozen = 0; m_timeout = 0;
    endfunction

    // Expected {pc,fd,de,em,mw enables, fd,de,em flushes, state} for the current inputs.
    function automatic logic [9:0] model_outputs();
        logic       mwc, luc;
        logic [4:0] en;
        logic [2:0] fl;
        logic [1:0] st;
        if (reset) return 10'b11111_000_00;
        mwc = i_mem_req && !i_mem_rdy;
        luc = i_ex_is_load && i_ex_reg_wr_en && (i_ex_rd != 5'd0) &&
              ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) || (i_id_use_rs2 && i_id_rs2 == i_ex_rd));
        st = m_frozen ? 2'd2 : (m_flush_left > 0) ? 2'd3 : m_lu_mask ? 2'd1 : 2'd0;
        if (mwc) begin
            en = 5'b00000; fl = 3'b000;
        end else if (i_mem_redirect) begin
            en = 5'b11111; fl = 3'b111;
        end else if (m_flush_left > 0) begin
            en = 5'b11111; fl = 3'b110;
        end else if (luc && !m_lu_mask) begin
            en = 5'b00111; fl = 3'b010;
        end else begin
            en = 5'b11111; fl = 3'b000;
        end
        return {en, fl, st};
    endfunction

    function automatic void model_advance();
        logic [9:0] e;
        logic       mwc;
        if (reset) begin
            model_reset();
            return;
        end
        e   = model_outputs();
        mwc = i_mem_req && !i_mem_rdy;
        if (!e[9] && m_stalls < CNT_MAX) m_stalls++;
        if (mwc) begin
            m_frozen = 1;
            m_wait++;
            if (m_wait >= TMO) m_timeout = 1;
        end else begin
            m_frozen = 0;
            m_wait   = 0;
            if (i_mem_redirect) begin
                m_flush_left = RF - 1;
                m_lu_mask    = 0;
                if (m_redirs < CNT_MAX) m_redirs++;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
                m_lu_mask = 0;
            end else begin
                m_lu_mask = !e[9];
            end
        end
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic ld,
                          input logic rdr, input logic req, input logic rdy);
        i_id_rs1 = rs1; i_id_rs2 = rs2; i_id_use_rs1 = u1; i_id_use_rs2 = u2;
        i_ex_rd = rd; i_ex_reg_wr_en = wr; i_ex_is_load = ld;
        i_mem_redirect = rdr; i_mem_req = req; i_mem_rdy = rdy;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] exp_vec;
        reset = 1'b1;
        set_in(5, 5, 1, 1, 5, 1, 1, 1, 0, 0);
        model_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #4;
            exp_vec = model_outputs();
            n_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL reset cyc%0d outputs: got %b expected %b", c, dut_vec, exp_vec);
            else n_pass++;
            n_total++;
            if ({o_stall_cycles, o_redirects, o_mem_timeout} !== '0)
                $display("FAIL reset cyc%0d counters: got %0d/%0d/%b expected 0/0/0",
                         c, o_stall_cycles, o_redirects, o_mem_timeout);
            else n_pass++;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        logic [9:0] exp_vec;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c < 2) set_in(5, 9, 1, 0, 5, 1, 1, 0, 0, 0);
            else       set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #3;
            exp_vec = model_outputs();
            n_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL load_use cyc%0d outputs: got %b expected %b", c, dut_vec, exp_vec);
            else n_pass++;
            n_total++;
            if ({o_stall_cycles, o_redirects, o_mem_timeout} !==
                {CNT_W'(m_stalls), CNT_W'(m_redirs), m_timeout})
                $display("FAIL load_use cyc%0d counters: got %0d/%0d/%b expected %0d/%0d/%b",
                         c, o_stall_cycles, o_redirects, o_mem_timeout, m_stalls, m_redirs, m_timeout);
            else n_pass++;
            @(posedge clk);
            model_advance();
            #1;
        end
        n_total++;
        if (o_stall_cycles !== CNT_W'(1))
            $display("FAIL load_use stall_total: got %0d expected 1", o_stall_cycles);
        else n_pass++;
        $display("test_load_use done");
    endtask

    task automatic test_rd_zero();
        logic [9:0] exp_vec;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c < 2) set_in(0, 3, 1, 0, 0, 1, 1, 0, 0, 0);
            else       set_in(4, 0, 0, 1, 0, 1, 1, 0, 0, 0);
            #3;
            exp_vec = model_outputs();
            n_total++;
            if (dut_vec !== exp_vec || !o_pc_en)
                $display("FAIL rd_zero cyc%0d outputs: got %b expected %b", c, dut_vec, exp_vec);
            else n_pass++;
            @(posedge clk);
            model_advance();
            #1;
        end
        $display("test_rd_zero done");
    endtask

    task automatic test_redirect();
        logic [9:0] exp_vec;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            // Load-use hazard alongside the redirect and during its flush window.
            if (c == 0)     set_in(5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
            else if (c == 1) set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
            else            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #3;
            exp_vec = model_outputs();
            n_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL redirect cyc%0d outputs: got %b expected %b", c, dut_vec, exp_vec);
            else n_pass++;
            n_total++;
            if ({o_stall_cycles, o_redirects} !== {CNT_W'(m_stalls), CNT_W'(m_redirs)})
                $display("FAIL redirect cyc%0d counters: got %0d/%0d expected %0d/%0d",
                         c, o_stall_cycles, o_redirects, m_stalls, m_redirs);
            else n_pass++;
            @(posedge clk);
            model_advance();
            #1;
        end
        $display("test_redirect done");
    endtask

    task automatic test_mem_wait_redirect();
        logic [9:0] exp_vec;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 0)     set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            else if (c < 4) set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            else if (c == 4) set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            else            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #3;
            exp_vec = model_outputs();
            n_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL memwait_redirect cyc%0d outputs: got %b expected %b", c, dut_vec, exp_vec);
            else n_pass++;
            n_total++;
            if ({o_stall_cycles, o_redirects, o_mem_timeout} !==
                {CNT_W'(m_stalls), CNT_W'(m_redirs), m_timeout})
                $display("FAIL memwait_redirect cyc%0d counters: got %0d/%0d/%b expected %0d/%0d/%b",
                         c, o_stall_cycles, o_redirects, o_mem_timeout, m_stalls, m_redirs, m_timeout);
            else n_pass++;
            @(posedge clk);
            model_advance();
            #1;
        end
        $display("test_mem_wait_redirect done");
    endtask

    task automatic test_timeout();
        logic [9:0] exp_vec;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 6)       set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            else if (c == 6) set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            else             set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #3;
            exp_vec = model_outputs();
            n_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL timeout cyc%0d outputs: got %b expected %b", c, dut_vec, exp_vec);
            else n_pass++;
            n_total++;
            if ({o_stall_cycles, o_mem_timeout} !== {CNT_W'(m_stalls), m_timeout})
                $display("FAIL timeout cyc%0d flag: got %0d/%b expected %0d/%b",
                         c, o_stall_cycles, o_mem_timeout, m_stalls, m_timeout);
            else n_pass++;
            @(posedge clk);
            model_advance();
            #1;
        end
        reset = 1'b1;
        #2;
        n_total++;
        if (o_mem_timeout !== 1'b0)
            $display("FAIL timeout clear_on_reset: got %b expected 0", o_mem_timeout);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp_vec;
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        model_advance();
        #1 set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #2;
        model_reset();
        exp_vec = model_outputs();
        n_total++;
        if (dut_vec !== exp_vec)
            $display("FAIL reset_mid outputs: got %b expected %b", dut_vec, exp_vec);
        else n_pass++;
        n_total++;
        if ({o_stall_cycles, o_redirects, o_mem_timeout} !== '0)
            $display("FAIL reset_mid counters: got %0d/%0d/%b expected 0/0/0",
                     o_stall_cycles, o_redirects, o_mem_timeout);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            model_advance();
            #4;
            exp_vec = model_outputs();
            n_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL reset_mid after cyc%0d outputs: got %b expected %b", c, dut_vec, exp_vec);
            else n_pass++;
        end
        @(posedge clk);
        model_advance();
        #1;
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_vec;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c < 300)      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            else if (c < 599) set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            else              set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            #3;
            exp_vec = model_outputs();
            n_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL back_to_back cyc%0d outputs: got %b expected %b", c, dut_vec, exp_vec);
            else n_pass++;
            n_total++;
            if ({o_stall_cycles, o_redirects, o_mem_timeout} !==
                {CNT_W'(m_stalls), CNT_W'(m_redirs), m_timeout})
                $display("FAIL back_to_back cyc%0d counters: got %0d/%0d/%b expected %0d/%0d/%b",
                         c, o_stall_cycles, o_redirects, o_mem_timeout, m_stalls, m_redirs, m_timeout);
            else n_pass++;
            @(posedge clk);
            model_advance();
            #1;
        end
        n_total++;
        if ({o_stall_cycles, o_redirects} !== {CNT_W'(CNT_MAX), CNT_W'(CNT_MAX)})
            $display("FAIL back_to_back saturation: got %0d/%0d expected %0d/%0d",
                     o_stall_cycles, o_redirects, CNT_MAX, CNT_MAX);
        else n_pass++;
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        logic [9:0] exp_vec;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 8),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 1),
                   1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 6));
            #3;
            exp_vec = model_outputs();
            n_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL random cyc%0d outputs: got %b expected %b", c, dut_vec, exp_vec);
            else n_pass++;
            n_total++;
            if ({o_stall_cycles, o_redirects, o_mem_timeout} !==
                {CNT_W'(m_stalls), CNT_W'(m_redirs), m_timeout})
                $display("FAIL random cyc%0d counters: got %0d/%0d/%b expected %0d/%0d/%b",
                         c, o_stall_cycles, o_redirects, o_mem_timeout, m_stalls, m_redirs, m_timeout);
            else n_pass++;
            @(posedge clk);
            model_advance();
            #1;
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_redirect();
        test_mem_wait_redirect();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
